// File: rtl/zbus_strobe_filter_pkg.sv
// Purpose: shared types and default timing constants for the Z80 strobe filter.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Consumers may be built with or without ZBUS_GLITCH_FILTER_EN.
package zbus_filter_pkg;

  // Access sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACTIVE  = 3'd2,
    HOLD    = 3'd3,
    WAITREL = 3'd4
  } state_e;

  // Latched access direction.
  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  // Active-low Z80 strobe levels as one bundle, iorq in the MSB.
  typedef struct packed {
    logic iorq;
    logic mreq;
    logic rd;
    logic wr;
  } zstb_t;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 3;
  localparam int DEF_HOLD_CYC  = 1;
  localparam int DEF_FILT_LEN  = 2;

  // Largest of four timing parameters; sizes the shared phase counter.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/zbus_strobe_filter_if.sv
// Purpose: Z80-side strobes/decodes in, chip-side strobes and enables out.
// Latency: n/a (wiring only).
// Backpressure: none; the Z80 side holds its strobes for the whole bus cycle.
interface zbus_strobe_filter_if;
  logic ziorq_n;
  logic zmreq_n;
  logic zrd_n;
  logic zwr_n;
  logic io_sel;
  logic mem_sel;
  logic brd_n;
  logic bwr_n;
  logic bd_oe;
  logic zd_oe;
  logic rd_latch;
  logic busy;

  // Bus/decoder side: drives the raw strobes and decodes, observes the chip side.
  modport master (
    output ziorq_n, zmreq_n, zrd_n, zwr_n, io_sel, mem_sel,
    input  brd_n, bwr_n, bd_oe, zd_oe, rd_latch, busy
  );

  // Filter block side.
  modport slave (
    input  ziorq_n, zmreq_n, zrd_n, zwr_n, io_sel, mem_sel,
    output brd_n, bwr_n, bd_oe, zd_oe, rd_latch, busy
  );
endinterface

// File: rtl/zbus_strobe_filter_deglitch.sv
// Purpose: one Z80 strobe: 2-FF synchronizer plus FILT_LEN run-length filter when ZBUS_GLITCH_FILTER_EN is defined.
// Latency: 2 + FILT_LEN fclk edges with the filter, 2 edges without.
// Backpressure: none; output follows the input after the filter settles.
module zbus_strobe_deglitch
`ifdef ZBUS_GLITCH_FILTER_EN
  #(parameter int FILT_LEN = zbus_filter_pkg::DEF_FILT_LEN)
`endif
(
  input  logic fclk,
  input  logic rst,
  input  logic raw_n,
  output logic filt_n
);

  logic s1_n;
  logic s2_n;

  // Two-flop synchronizer; resets to the inactive (high) level.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      s1_n <= 1'b1;
      s2_n <= 1'b1;
    end else begin
      s1_n <= raw_n;
      s2_n <= s1_n;
    end
  end

`ifdef ZBUS_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN) + 1;

  logic [FW-1:0] run_cnt;
  logic          filt_q;

  // Flip the filtered level only after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
      filt_q  <= 1'b1;
    end else if (s2_n == filt_q) begin
      run_cnt <= '0;
    end else if (run_cnt == FW'(FILT_LEN - 1)) begin
      run_cnt <= '0;
      filt_q  <= s2_n;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign filt_n = filt_q;
`else
  // No run-length filter: a single-cycle glitch that survives sync gets through.
  assign filt_n = s2_n;
`endif

endmodule

// File: rtl/zbus_strobe_filter.sv
// Purpose: qualify filtered Z80 strobes and emit one timed brd_n/bwr_n pulse per access (ZBUS_GLITCH_FILTER_EN adds the deglitch filter).
// Latency: raw strobe edge to chip strobe = 2 + FILT_LEN (0 without filter) + 1 + SETUP_CYC fclk edges.
// Backpressure: none; after an access the sequencer waits for the Z80 to drop the strobes before re-arming.
module zbus_strobe_filter
  import zbus_filter_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int FILT_LEN  = DEF_FILT_LEN
) (
  input  logic                 fclk,
  input  logic                 rst,
  zbus_strobe_filter_if.slave  bus
);

  localparam int CW = $clog2(max_of4(SETUP_CYC, PULSE_CYC, HOLD_CYC, FILT_LEN)) + 1;

  logic [3:0] raw_vec;
  logic [3:0] filt_vec;
  zstb_t      f;

  assign raw_vec = {bus.ziorq_n, bus.zmreq_n, bus.zrd_n, bus.zwr_n};
  assign f       = zstb_t'(filt_vec);

  for (genvar i = 0; i < 4; i++) begin : g_dg
    zbus_strobe_deglitch
`ifdef ZBUS_GLITCH_FILTER_EN
      #(.FILT_LEN(FILT_LEN))
`endif
      u_dg (
        .fclk   (fclk),
        .rst    (rst),
        .raw_n  (raw_vec[i]),
        .filt_n (filt_vec[i])
      );
  end

  // Qualification: a selected space with exactly one of rd/wr asserted.
  logic act, rdq, wrq, req;
  assign act = (~f.iorq & bus.io_sel) | (~f.mreq & bus.mem_sel);
  assign rdq = act & ~f.rd &  f.wr;
  assign wrq = act & ~f.wr &  f.rd;

  state_e        state, state_d;
  dir_e          dir, dir_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          brd_n_d, bwr_n_d, bd_oe_d, zd_oe_d, rd_latch_d, busy_d;

  // Request still present in the latched direction (abort check during SETUP).
  assign req = (dir == DIR_WR) ? wrq : rdq;

  // State, phase counter and registered outputs.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dir          <= DIR_RD;
      cnt          <= '0;
      bus.brd_n    <= 1'b1;
      bus.bwr_n    <= 1'b1;
      bus.bd_oe    <= 1'b0;
      bus.zd_oe    <= 1'b0;
      bus.rd_latch <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      state        <= state_d;
      dir          <= dir_d;
      cnt          <= cnt_d;
      bus.brd_n    <= brd_n_d;
      bus.bwr_n    <= bwr_n_d;
      bus.bd_oe    <= bd_oe_d;
      bus.zd_oe    <= zd_oe_d;
      bus.rd_latch <= rd_latch_d;
      bus.busy     <= busy_d;
    end
  end

  // Next state; the counter is loaded on entry and counts down to zero.
  always_comb begin
    state_d = state;
    dir_d   = dir;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (rdq || wrq) begin
          state_d = SETUP;
          dir_d   = wrq ? DIR_WR : DIR_RD;
          cnt_d   = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        // Once setup has elapsed the pulse is committed, even if the request just dropped.
        if (cnt == '0) begin
          state_d = ACTIVE;
          cnt_d   = CW'(PULSE_CYC - 1);
        end else if (!req) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_d = (rdq || wrq) ? WAITREL : IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      WAITREL: begin
        if (!rdq && !wrq) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the upcoming state, registered alongside it.
  always_comb begin
    brd_n_d    = !(state_d == ACTIVE && dir_d == DIR_RD);
    bwr_n_d    = !(state_d == ACTIVE && dir_d == DIR_WR);
    bd_oe_d    = (dir_d == DIR_WR) && (state_d inside {SETUP, ACTIVE, HOLD});
    zd_oe_d    = (dir_d == DIR_RD) && (state_d inside {HOLD, WAITREL});
    rd_latch_d = (dir_d == DIR_RD) && (state_d == ACTIVE) && (cnt_d == '0);
    busy_d     = (state_d != IDLE);
  end

endmodule
